// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line mover: FSM state encoding,
// line/beat geometry and a beat extraction helper.
package cache_pkg;

    localparam int IDX_W  = 5;
    localparam int LINE_W = 128;
    localparam int BEAT_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int BE_W   = LINE_W / 8;
    localparam int CNT_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        FILL_COLLECT,
        FILL_WRITE,
        EV_READ,
        EV_WAIT,
        EV_SEND
    } lm_state_e;

    function automatic logic [BEAT_W-1:0] beat_slice(input logic [LINE_W-1:0] line,
                                                     input logic [CNT_W-1:0]  idx);
        return line[idx*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/lm_line_buf.sv
// One-line staging buffer: beat-granular writes for refill assembly, whole-line
// load for victim capture, and a beat read mux for writeback streaming.
module lm_line_buf
    import cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              beat_we_i,
    input  logic [CNT_W-1:0]  beat_idx_i,
    input  logic [BEAT_W-1:0] beat_data_i,
    input  logic              line_ld_i,
    input  logic [LINE_W-1:0] line_data_i,
    input  logic [CNT_W-1:0]  rd_idx_i,
    output logic [BEAT_W-1:0] rd_data_o,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    // A line load and a beat write never coincide; the load takes priority anyway.
    always_comb begin
        line_d = line_q;
        if (line_ld_i) begin
            line_d = line_data_i;
        end else if (beat_we_i) begin
            line_d[beat_idx_i*BEAT_W +: BEAT_W] = beat_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign rd_data_o = beat_slice(line_q, rd_idx_i);
    assign line_o    = line_q;

endmodule

// File: rtl/cache_line_mover.sv
// Refill/writeback sequencer for the two-way cache data array.
// Optional critical-beat forward path enabled by CACHE_LINE_MOVER_FWD_EN.
//
// state        | meaning
// IDLE         | ready for a refill or writeback request (writeback wins)
// FILL_COLLECT | accepting 4 refill beats into the line buffer
// FILL_WRITE   | one-cycle full-line write into the selected way
// EV_READ      | one-cycle array read of the victim set
// EV_WAIT      | capture selected way's read data into the line buffer
// EV_SEND      | stream 4 writeback beats
module cache_line_mover
    import cache_pkg::*;
(
    input  logic              CK,
    input  logic              RST,
    input  logic              fill_req_valid,
    output logic              fill_req_ready,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic              fill_way,
    input  logic              fill_beat_valid,
    output logic              fill_beat_ready,
    input  logic [BEAT_W-1:0] fill_beat_data,
    input  logic              evict_req_valid,
    output logic              evict_req_ready,
    input  logic [IDX_W-1:0]  evict_idx,
    input  logic              evict_way,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [BEAT_W-1:0] wb_data,
    output logic              wb_last,
    output logic              fwd_valid,
    output logic [BEAT_W-1:0] fwd_data,
    output logic [1:0]        fwd_beat,
    output logic              op_done,
    output logic              busy,
    output logic              CS,
    output logic              OE,
    output logic [IDX_W-1:0]  A,
    output logic [BE_W-1:0]   WEB1,
    output logic [BE_W-1:0]   WEB2,
    output logic [LINE_W-1:0] DI,
    input  logic [LINE_W-1:0] DO1,
    input  logic [LINE_W-1:0] DO2
);

    lm_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              way_q, way_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              beat_we;
    logic              line_ld;
    logic [BEAT_W-1:0] rd_beat;
    logic [LINE_W-1:0] line;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        way_d           = way_q;
        cnt_d           = cnt_q;
        beat_we         = 1'b0;
        line_ld         = 1'b0;
        fill_req_ready  = 1'b0;
        evict_req_ready = 1'b0;
        fill_beat_ready = 1'b0;
        wb_valid        = 1'b0;
        wb_last         = 1'b0;
        op_done         = 1'b0;
        CS              = 1'b0;
        OE              = 1'b0;
        WEB1            = '0;
        WEB2            = '0;

        case (state_q)
            IDLE: begin
                fill_req_ready  = 1'b1;
                evict_req_ready = 1'b1;
                if (evict_req_valid) begin
                    idx_d   = evict_idx;
                    way_d   = evict_way;
                    cnt_d   = '0;
                    state_d = EV_READ;
                end else if (fill_req_valid) begin
                    idx_d   = fill_idx;
                    way_d   = fill_way;
                    cnt_d   = '0;
                    state_d = FILL_COLLECT;
                end
            end
            FILL_COLLECT: begin
                fill_beat_ready = 1'b1;
                if (fill_beat_valid) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = FILL_WRITE;
                    end
                end
            end
            FILL_WRITE: begin
                CS      = 1'b1;
                op_done = 1'b1;
                if (way_q) begin
                    WEB2 = '1;
                end else begin
                    WEB1 = '1;
                end
                state_d = IDLE;
            end
            EV_READ: begin
                CS      = 1'b1;
                OE      = 1'b1;
                state_d = EV_WAIT;
            end
            EV_WAIT: begin
                line_ld = 1'b1;
                state_d = EV_SEND;
            end
            EV_SEND: begin
                wb_valid = 1'b1;
                wb_last  = (cnt_q == CNT_W'(BEATS - 1));
                if (wb_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (wb_last) begin
                        op_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            way_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
        end
    end

    lm_line_buf u_line_buf (
        .clk_i       (CK),
        .rst_i       (RST),
        .beat_we_i   (beat_we),
        .beat_idx_i  (cnt_q),
        .beat_data_i (fill_beat_data),
        .line_ld_i   (line_ld),
        .line_data_i (way_q ? DO2 : DO1),
        .rd_idx_i    (cnt_q),
        .rd_data_o   (rd_beat),
        .line_o      (line)
    );

    // A and DI are only meaningful while CS is high; elsewhere they just hold.
    assign A       = idx_q;
    assign DI      = line;
    assign wb_data = rd_beat;
    assign busy    = (state_q != IDLE);

`ifdef CACHE_LINE_MOVER_FWD_EN
    logic              fwd_valid_q;
    logic [BEAT_W-1:0] fwd_data_q;
    logic [1:0]        fwd_beat_q;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            fwd_beat_q  <= '0;
        end else begin
            fwd_valid_q <= beat_we;
            if (beat_we) begin
                fwd_data_q <= fill_beat_data;
                fwd_beat_q <= cnt_q;
            end
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_data  = fwd_data_q;
    assign fwd_beat  = fwd_beat_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_data  = '0;
    assign fwd_beat  = '0;
`endif

endmodule
